// File: rtl/nn_pkg.sv
// Shared types and helpers for the classifier back-end blocks.
package nn_pkg;

  localparam int NN_WIDTH = 16;
  localparam int NN_FRAC  = 8;

  typedef logic signed [NN_WIDTH-1:0] prob_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2
  } argmax_state_e;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Signed strictly-greater compare with value/index select; equal values keep
// the incumbent so ties go to the lower index.
module argmax_cmp #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 2
) (
  input  logic signed [WIDTH-1:0] cur_val,
  input  logic        [IDX_W-1:0] cur_idx,
  input  logic signed [WIDTH-1:0] cand_val,
  input  logic        [IDX_W-1:0] cand_idx,
  output logic signed [WIDTH-1:0] sel_val,
  output logic        [IDX_W-1:0] sel_idx
);

  logic gt;

  assign gt      = cand_val > cur_val;
  assign sel_val = gt ? cand_val : cur_val;
  assign sel_idx = gt ? cand_idx : cur_idx;

endmodule

// File: rtl/softmax_argmax_stream.sv
// Captures a batch of class probabilities, scans each sample one class per
// cycle and streams out one argmax result per sample.
module softmax_argmax_stream
  import nn_pkg::*;
#(
  parameter  int WIDTH    = NN_WIDTH,
  parameter  int FRAC     = NN_FRAC,
  parameter  int OUT_SIZE = 3,
  parameter  int BATCH    = 15,
  localparam int CLS_W    = clog2_min1(OUT_SIZE),
  localparam int IDX_W    = clog2_min1(BATCH)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [BATCH-1:0][OUT_SIZE-1:0][WIDTH-1:0] in_probs,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [CLS_W-1:0]                          out_class,
  output logic signed [WIDTH-1:0]                   out_conf,
  output logic [IDX_W-1:0]                          out_idx,
  output logic                                      out_last
);

  // FRAC only describes the number format; nothing here rescales.
  if (FRAC < 0 || FRAC >= WIDTH || OUT_SIZE < 1 || BATCH < 1) begin : g_bad_cfg
    $error("softmax_argmax_stream: illegal parameter set");
  end

  argmax_state_e state, state_nxt;

  logic [BATCH-1:0][OUT_SIZE-1:0][WIDTH-1:0] bank;
  logic [IDX_W-1:0]        b, b_inc;
  logic [CLS_W-1:0]        k, bestk, sel_idx;
  logic signed [WIDTH-1:0] best, cand, nxt_first, sel_val;
  logic                    capture, scan_done;

  assign capture   = in_valid && in_ready;
  assign scan_done = (k == CLS_W'(OUT_SIZE-1));
  assign b_inc     = b + IDX_W'(1);

  // Row/column selection written as compare-select so no index is wider or
  // narrower than the array it addresses.
  always_comb begin
    cand      = '0;
    nxt_first = '0;
    for (int i = 0; i < BATCH; i++) begin
      if (b_inc == IDX_W'(i)) nxt_first = bank[i][0];
      for (int j = 0; j < OUT_SIZE; j++)
        if (b == IDX_W'(i) && k == CLS_W'(j)) cand = bank[i][j];
    end
  end

  argmax_cmp #(.WIDTH(WIDTH), .IDX_W(CLS_W)) u_cmp (
    .cur_val (best),
    .cur_idx (bestk),
    .cand_val(cand),
    .cand_idx(k),
    .sel_val (sel_val),
    .sel_idx (sel_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (capture)   state_nxt = (OUT_SIZE == 1) ? ST_EMIT : ST_SCAN;
      ST_SCAN: if (scan_done) state_nxt = ST_EMIT;
      ST_EMIT: if (out_ready)
                 state_nxt = out_last ? ST_IDLE : ((OUT_SIZE == 1) ? ST_EMIT : ST_SCAN);
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_class <= '0;
      out_conf  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      bank      <= '0;
      b         <= '0;
      k         <= '0;
      best      <= '0;
      bestk     <= '0;
    end else begin
      // One full IDLE cycle precedes in_ready, so a finished batch never
      // re-arms on the same edge as its final accept.
      in_ready <= (state == ST_IDLE) && (state_nxt == ST_IDLE);
      unique case (state)
        ST_IDLE: if (capture) begin
          bank  <= in_probs;
          b     <= '0;
          best  <= in_probs[0][0];
          bestk <= '0;
          k     <= CLS_W'(1);
          if (OUT_SIZE == 1) begin
            out_valid <= 1'b1;
            out_class <= '0;
            out_conf  <= in_probs[0][0];
            out_idx   <= '0;
            out_last  <= (BATCH == 1);
          end
        end
        ST_SCAN: begin
          best  <= sel_val;
          bestk <= sel_idx;
          k     <= k + CLS_W'(1);
          if (scan_done) begin
            out_valid <= 1'b1;
            out_class <= sel_idx;
            out_conf  <= sel_val;
            out_idx   <= b;
            out_last  <= (b == IDX_W'(BATCH-1));
          end
        end
        ST_EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          if (!out_last) begin
            b     <= b_inc;
            best  <= nxt_first;
            bestk <= '0;
            k     <= CLS_W'(1);
            if (OUT_SIZE == 1) begin
              out_valid <= 1'b1;
              out_class <= '0;
              out_conf  <= nxt_first;
              out_idx   <= b_inc;
              out_last  <= (b_inc == IDX_W'(BATCH-1));
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
